// File: rtl/dm_read_llsc_pkg.sv
// Shared encodings for the data-memory read path and LL/SC reservation.
package dm_read_llsc_pkg;

  localparam int unsigned DATA_W        = 32;
  localparam int unsigned ADDR_W_DEF    = 32;
  localparam int unsigned RESV_GRAN_DEF = 2;
  localparam int unsigned LD_OP_W       = 3;
  localparam int unsigned LD_SIGN_BIT   = 2;

  // Access width carried in load_op[1:0]
  typedef enum logic [1:0] {
    LD_WORD = 2'b00,
    LD_HALF = 2'b01,
    LD_BYTE = 2'b10,
    LD_NONE = 2'b11
  } ld_width_e;

  // load_op = {sign, width}
  typedef struct packed {
    logic      sign;
    ld_width_e width;
  } load_op_t;

  localparam load_op_t LOAD_OP_NONE = '{sign: 1'b0, width: LD_NONE};

  // Reservation FSM states
  typedef enum logic {
    NO_RESV = 1'b0,
    RESV    = 1'b1
  } resv_state_e;

  // Everything the W stage needs to finish a load or SC
  typedef struct packed {
    load_op_t   op;
    logic [1:0] addr_low;
    logic       is_sc;
    logic       sc_ok;
    logic       valid;
  } w_stage_t;

  localparam w_stage_t W_STAGE_RESET = '{
    op:       LOAD_OP_NONE,
    addr_low: 2'b00,
    is_sc:    1'b0,
    sc_ok:    1'b0,
    valid:    1'b0
  };

  // True when a load of the given width is not naturally aligned
  function automatic logic ld_misaligned(input load_op_t op, input logic [1:0] addr_low);
    logic mis;
    mis = 1'b0;
    case (op.width)
      LD_WORD: mis = (addr_low != 2'b00);
      LD_HALF: mis = addr_low[0];
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dm_read_llsc_load_extend.sv
// Combinational byte/half/word extractor with sign or zero extension.
module dm_read_llsc_load_extend
  import dm_read_llsc_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr_low,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  load_op_t    op_s;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed lane, then extend according to width and sign
  always_comb begin
    op_s     = load_op_t'(op);
    half_sel = addr_low[1] ? rdata[31:16] : rdata[15:0];
    case (addr_low)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    case (op_s.width)
      LD_WORD: result = rdata;
      LD_HALF: result = {{16{op_s.sign & half_sel[15]}}, half_sel};
      LD_BYTE: result = {{24{op_s.sign & byte_sel[7]}}, byte_sel};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/dm_read_llsc.sv
// Read end of the data-memory port: W-stage load extraction and LL/SC reservation.
module dm_read_llsc
  import dm_read_llsc_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned RESV_GRAN = RESV_GRAN_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m_valid,
  input  logic              m_flush,
  input  logic              m_eret,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [2:0]        m_load_op,
  input  logic              m_is_ll,
  input  logic              m_is_sc,
  input  logic              m_is_store,
  input  logic              w_en,
  input  logic [31:0]       w_rdata,
  output logic              m_llbit,
  output logic              m_addr_err,
  output logic              w_valid,
  output logic [31:0]       w_load_data
);

  localparam int unsigned TAG_W = ADDR_W - RESV_GRAN;

  load_op_t    m_op;
  logic        m_is_load;
  logic        resv_hit;
  w_stage_t    w_q, w_d;
  resv_state_e resv_state_q, resv_state_d;
  logic [TAG_W-1:0] resv_addr_q, resv_addr_d;
  logic [31:0] ext_data;

  // M-stage decode: load detection, alignment check and reservation tag compare
  always_comb begin
    m_op       = load_op_t'(m_load_op);
    m_is_load  = (m_op.width != LD_NONE);
    m_addr_err = m_is_load & ld_misaligned(m_op, m_addr[1:0]);
    resv_hit   = (m_addr[ADDR_W-1:RESV_GRAN] == resv_addr_q);
  end

  assign m_llbit = (resv_state_q == RESV);

  // Next W-stage contents; killed, idle or misaligned M slots become bubbles
  always_comb begin
    w_d = w_q;
    if (w_en) begin
      w_d.op       = m_op;
      w_d.addr_low = m_addr[1:0];
      w_d.is_sc    = m_is_sc;
      w_d.sc_ok    = m_llbit;
      w_d.valid    = m_valid & ~m_flush & (m_is_sc | (m_is_load & ~m_addr_err));
      if (!m_valid || m_flush || m_addr_err) begin
        w_d.op = LOAD_OP_NONE;
      end
      if (!m_valid || m_flush) begin
        w_d.is_sc = 1'b0;
      end
    end
  end

  // Reservation next state; flush/eret clear it even without a commit
  always_comb begin
    resv_state_d = resv_state_q;
    resv_addr_d  = resv_addr_q;
    if (m_flush || m_eret) begin
      resv_state_d = NO_RESV;
    end else if (m_valid) begin
      if (m_is_sc) begin
        resv_state_d = NO_RESV;
      end else if (m_is_ll) begin
        if (!m_addr_err) begin
          resv_state_d = RESV;
          resv_addr_d  = m_addr[ADDR_W-1:RESV_GRAN];
        end
      end else if (m_is_store && resv_hit) begin
        resv_state_d = NO_RESV;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      w_q          <= W_STAGE_RESET;
      resv_state_q <= NO_RESV;
      resv_addr_q  <= '0;
    end else begin
      w_q          <= w_d;
      resv_state_q <= resv_state_d;
      resv_addr_q  <= resv_addr_d;
    end
  end

  dm_read_llsc_load_extend u_load_extend (
    .op       (w_q.op),
    .addr_low (w_q.addr_low),
    .rdata    (w_rdata),
    .result   (ext_data)
  );

  assign w_valid     = w_q.valid;
  assign w_load_data = w_q.is_sc ? {{(DATA_W-1){1'b0}}, w_q.sc_ok} : ext_data;

endmodule

// File: tb/tb_dm_read_llsc.sv
// Scoreboard bench for dm_read_llsc: M-stage stimulus, W-stage results one cycle later.
module tb_dm_read_llsc;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LHU = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_NO  = 3'b011;
  localparam logic [2:0] OP_LH  = 3'b101;
  localparam logic [2:0] OP_LB  = 3'b110;

  // ctl = {valid, flush, eret, ll, sc, store}
  localparam logic [5:0] C_BUB   = 6'b000000;
  localparam logic [5:0] C_LD    = 6'b100000;
  localparam logic [5:0] C_LL    = 6'b100100;
  localparam logic [5:0] C_SC    = 6'b100010;
  localparam logic [5:0] C_ST    = 6'b100001;
  localparam logic [5:0] C_ERET  = 6'b101000;
  localparam logic [5:0] C_FL    = 6'b110000;
  localparam logic [5:0] C_FL_NV = 6'b010000;
  localparam logic [5:0] C_LL_FL = 6'b110100;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_valid, m_flush, m_eret, m_is_ll, m_is_sc, m_is_store, w_en;
  logic [31:0] m_addr, w_rdata, w_load_data;
  logic [2:0]  m_load_op;
  logic        m_llbit, m_addr_err, w_valid;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [32:0] exp_q[$];
  string       tag_q[$];
  logic [31:0] pend_rdata = 32'h0;

  always #5 clk = ~clk;

  dm_read_llsc #(.ADDR_W(32), .RESV_GRAN(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .m_valid     (m_valid),
    .m_flush     (m_flush),
    .m_eret      (m_eret),
    .m_addr      (m_addr),
    .m_load_op   (m_load_op),
    .m_is_ll     (m_is_ll),
    .m_is_sc     (m_is_sc),
    .m_is_store  (m_is_store),
    .w_en        (w_en),
    .w_rdata     (w_rdata),
    .m_llbit     (m_llbit),
    .m_addr_err  (m_addr_err),
    .w_valid     (w_valid),
    .w_load_data (w_load_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_m(input logic [2:0] op, input logic [31:0] addr, input logic [5:0] ctl);
    m_load_op  = op;
    m_addr     = addr;
    {m_valid, m_flush, m_eret, m_is_ll, m_is_sc, m_is_store} = ctl;
  endtask

  // One M-stage instruction; also checks the W result of the previous one
  task automatic step(input string tag, input logic [2:0] op, input logic [31:0] addr,
                      input logic [5:0] ctl, input logic [31:0] rdata,
                      input logic exp_llbit, input logic exp_aerr,
                      input logic exp_wv, input logic [31:0] exp_wd);
    logic [32:0] e;
    string       t;
    @(posedge clk); #1;
    w_rdata    = pend_rdata;
    pend_rdata = rdata;
    w_en       = 1'b1;
    drive_m(op, addr, ctl);
    exp_q.push_back({exp_wv, exp_wd});
    tag_q.push_back(tag);
    @(negedge clk);
    check({tag, ".llbit"}, 32'(m_llbit), 32'(exp_llbit));
    check({tag, ".aerr"}, 32'(m_addr_err), 32'(exp_aerr));
    if (exp_q.size() > 1) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check({t, ".wvalid"}, 32'(w_valid), 32'(e[32]));
      check({t, ".wdata"}, w_load_data, e[31:0]);
    end
  endtask

  // Hold W for n cycles while M offers a load that must not be captured
  task automatic stall(input int n);
    logic [32:0] e;
    e = exp_q[0];
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      w_rdata = pend_rdata;
      w_en    = 1'b0;
      drive_m(OP_LB, 32'h3, C_BUB);
      @(negedge clk);
      check("stall.wvalid", 32'(w_valid), 32'(e[32]));
      check("stall.wdata", w_load_data, e[31:0]);
    end
    void'(exp_q.pop_front());
    void'(tag_q.pop_front());
  endtask

  initial begin
    reset   = 1'b1;
    w_en    = 1'b1;
    w_rdata = 32'hFFFF_FFFF;
    drive_m(OP_LW, 32'h0, C_LL);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.wvalid", 32'(w_valid), 32'h0);
    check("rst.wdata", w_load_data, 32'h0);
    check("rst.llbit", 32'(m_llbit), 32'h0);
    reset = 1'b0;
    drive_m(OP_NO, 32'h0, C_BUB);

    // Extraction
    step("lb",   OP_LB,  32'h0000_0003, C_LD, 32'h80FF_1234, 1'b0, 1'b0, 1'b1, 32'hFFFF_FF80);
    step("lbu",  OP_LBU, 32'h0000_0003, C_LD, 32'h80FF_1234, 1'b0, 1'b0, 1'b1, 32'h0000_0080);
    step("lh",   OP_LH,  32'h0000_0002, C_LD, 32'h9ABC_0000, 1'b0, 1'b0, 1'b1, 32'hFFFF_9ABC);
    step("lhu",  OP_LHU, 32'h0000_0000, C_LD, 32'h0000_F00D, 1'b0, 1'b0, 1'b1, 32'h0000_F00D);
    step("lh_mis", OP_LH, 32'h0000_0001, C_LD, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 32'h0);
    // LL then SC back-to-back
    step("ll1",  OP_LW,  32'h100, C_LL,  32'h1111_2222, 1'b0, 1'b0, 1'b1, 32'h1111_2222);
    step("sc1",  OP_NO,  32'h100, C_SC,  32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 32'h1);
    step("bub1", OP_NO,  32'h0,   C_BUB, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0);
    // Store to the reserved word kills the SC
    step("ll2",  OP_LW,  32'h100, C_LL,  32'h0000_0042, 1'b0, 1'b0, 1'b1, 32'h0000_0042);
    step("sw102", OP_NO, 32'h102, C_ST,  32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'h0);
    step("sc2",  OP_NO,  32'h100, C_SC,  32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 32'h0);
    // Store to a neighbouring word leaves it intact
    step("ll3",  OP_LW,  32'h100, C_LL,  32'hA5A5_0001, 1'b0, 1'b0, 1'b1, 32'hA5A5_0001);
    step("sw104", OP_NO, 32'h104, C_ST,  32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'h0);
    step("sc3",  OP_NO,  32'h100, C_SC,  32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 32'h1);
    // ERET and flush between LL and SC
    step("ll4",  OP_LW,  32'h100, C_LL,  32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
    step("eret", OP_NO,  32'h0,   C_ERET, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    step("sc4",  OP_NO,  32'h100, C_SC,  32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 32'h0);
    step("ll5",  OP_LW,  32'h100, C_LL,  32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
    step("flush", OP_NO, 32'h0,   C_FL,  32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    step("sc5",  OP_NO,  32'h100, C_SC,  32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 32'h0);
    // Flushed LL never reserves
    step("ll_fl", OP_LW, 32'h100, C_LL_FL, 32'h7777_7777, 1'b0, 1'b0, 1'b0, 32'h0);
    step("sc6",  OP_NO,  32'h100, C_SC,  32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 32'h0);
    // Flush without a valid M instruction still clears
    step("ll7",  OP_LW,  32'h300, C_LL,  32'h3333_3333, 1'b0, 1'b0, 1'b1, 32'h3333_3333);
    step("fl_nv", OP_NO, 32'h0,   C_FL_NV, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    step("sc7",  OP_NO,  32'h300, C_SC,  32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 32'h0);
    // Misaligned LL neither loads nor reserves
    step("ll_mis", OP_LW, 32'h101, C_LL, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 32'h0);
    step("sc8",  OP_NO,  32'h100, C_SC,  32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 32'h0);
    // Stall with the load held in W
    step("lw",   OP_LW,  32'h8,   C_LD,  32'hCAFE_F00D, 1'b0, 1'b0, 1'b1, 32'hCAFE_F00D);
    stall(3);
    step("bub2", OP_NO,  32'h0,   C_BUB, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    step("ll8",  OP_LW,  32'h200, C_LL,  32'h55AA_55AA, 1'b0, 1'b0, 1'b1, 32'h55AA_55AA);

    // Reset mid-operation, with a live LL in W and the reservation set
    @(posedge clk); #1;
    w_rdata = pend_rdata;
    reset   = 1'b1;
    drive_m(OP_LW, 32'h0, C_LL);
    @(negedge clk);
    check("pre_rst.llbit", 32'(m_llbit), 32'h1);
    check("ll8.wvalid", 32'(w_valid), 32'(exp_q[0][32]));
    check("ll8.wdata", w_load_data, exp_q[0][31:0]);
    exp_q.delete();
    tag_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    drive_m(OP_NO, 32'h0, C_BUB);
    @(negedge clk);
    check("mid_rst.wvalid", 32'(w_valid), 32'h0);
    check("mid_rst.wdata", w_load_data, 32'h0);
    check("mid_rst.llbit", 32'(m_llbit), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net against a stuck simulation
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dm_read_llsc.md
Name: dm_read_llsc

Overview:
- Load-side counterpart of the store byte-enable/alignment logic: the read end of the data-memory port.
- Captures the load type and low address bits in M. One cycle later in W, extracts and sign/zero-extends the byte, half or word from the 32-bit DM read data.
- Owns the LL/SC reservation state (llbit plus reservation address), which the store path uses to gate SC writes, and produces the SC success value written back to rt.

Parameters:
- ADDR_W, 32, width of the data address.
- RESV_GRAN, 2, number of low address bits ignored in the reservation compare (word granularity).

Ports:
- clk  input  1  system clock; one clock domain; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- m_valid  input  1  the M-stage instruction is real and commits this cycle.
- m_flush  input  1  exception/interrupt taken at M; the M instruction is killed.
- m_eret  input  1  ERET committing in M.
- m_addr  input  ADDR_W  effective data address in M.
- m_load_op  input  3  {sign, width[1:0]}; width 00 word, 01 half, 10 byte, 11 none.
- m_is_ll  input  1  M instruction is LL (also a word load).
- m_is_sc  input  1  M instruction is SC.
- m_is_store  input  1  M instruction is SW/SH/SB (excludes SC).
- w_en  input  1  W pipeline register enable; 0 holds all W registers.
- w_rdata  input  32  raw DM read word for the instruction in W.
- m_llbit  output  1  current reservation bit; drives the store-side sc_check gating.
- m_addr_err  output  1  combinational; misaligned load in M.
- w_valid  output  1  W holds a load or SC whose result must be written back.
- w_load_data  output  32  extracted, extended load result, or the SC result.

Behaviour:
- Reset: llbit=0, resv_addr=0, W op=none, w_valid=0, w_load_data=0.
- M capture (w_en=1):
  - W registers take {load_op, m_addr[1:0], is_sc, sc_ok=llbit}.
  - If m_flush=1 or m_valid=0, W op=none and w_valid=0.
- Latency: result valid in W exactly 1 cycle after the M commit. Extraction is combinational from the W registers and w_rdata.
- Extraction, with b = byte at addr[1:0]:
  - word: w_rdata.
  - half: w_rdata[31:16] if addr[1] else w_rdata[15:0]; bit 15 sign-extended if sign=1, else zero-extended.
  - byte: b; bit 7 sign-extended if sign=1, else zero-extended.
  - none: 0.
- SC in W: w_load_data = {31'b0, sc_ok}; w_valid=1; w_rdata is ignored.
- m_addr_err = load and ((width=word and addr[1:0]!=0) or (width=half and addr[0]=1)).
  - The block does not trap. On m_addr_err the W op is forced to none.
- Reservation update, when m_valid=1 and !m_flush, in this priority order:
  - flush or eret: llbit <= 0 (overrides everything, regardless of m_valid).
  - SC commit: llbit <= 0.
  - LL commit without addr_err: llbit <= 1; resv_addr <= m_addr[ADDR_W-1:RESV_GRAN].
  - store commit with m_addr[ADDR_W-1:RESV_GRAN] == resv_addr: llbit <= 0.
  - otherwise: hold.
- m_llbit is the registered value. An SC immediately after an LL (back-to-back in M) sees llbit=1.
- Stall (w_en=0): W registers hold, and w_load_data stays stable against a held w_rdata. Reservation updates still apply only on m_valid commits, so the caller must deassert m_valid during a stall.
- Reset asserted mid-operation clears the reservation and the W op in the same edge.

Decomposition:
- Shared package: width encodings (WORD/HALF/BYTE/NONE), the load_op bit positions, and the RESV_GRAN default.
- Natural sub-module: load_extend, a pure combinational extractor taking {op, addr_low, rdata} and producing the result. The top level keeps the W registers and the reservation FSM (two states: NO_RESV, RESV).

Test Plan:
- LB at addr ...03, w_rdata=0x80FF1234 -> w_load_data=0xFFFFFF80. LBU at the same address -> 0x00000080.
- LH at addr ...02, rdata=0x9ABC0000 -> 0xFFFF9ABC. LHU at addr ...00, rdata=0x0000F00D -> 0x0000F00D. LH at ...01 -> m_addr_err=1, w_valid=0.
- LL at 0x100, then SC at 0x100 -> m_llbit=1 during the SC; W result=0x00000001; llbit=0 afterwards.
- LL at 0x100, SW at 0x102, then SC -> llbit cleared by the store; SC result 0x0. Variant with SW at 0x104: SC result 0x1.
- LL, then m_flush or m_eret asserted before the SC -> llbit=0; SC result 0. A flushed LL never sets llbit.
- Load in W with w_en=0 for 3 cycles -> w_load_data constant. Reset pulse -> all outputs 0 on the next edge.
